// File: rtl/simd_divider.sv
// Iterative packed-SIMD unsigned restoring divider: one quotient bit per clock on
// every lane in parallel, lane width selected by a thermometer sew code.
module simd_divider #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SEW_WIDTH-1:0]           sew,
  input  logic [MAX_WIDTH-1:0]           dividend,
  input  logic [MAX_WIDTH-1:0]           divisor,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MAX_WIDTH-1:0]           quotient,
  output logic [MAX_WIDTH-1:0]           remainder,
  output logic [MAX_WIDTH/MIN_WIDTH-1:0] dbz
);

  localparam int NS = MAX_WIDTH / MIN_WIDTH;
  localparam int NW = $clog2(NS) + 1;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = $clog2(MAX_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [MAX_WIDTH-1:0]  dvd_q, dsr_q, rem_q;
  logic [KW-1:0]         k_q, k_dec;
  logic [CW-1:0]         cnt_q;

  // Candidate next state for every legal lane width; k_q picks one.
  logic [NW-1:0][MAX_WIDTH-1:0] rem_nxt, dvd_nxt;
  logic [NW-1:0][NS-1:0]        dbz_lane;

  function automatic logic [SEW_WIDTH-1:0] therm(input int n);
    logic [SEW_WIDTH-1:0] ones;
    ones  = '1;
    therm = ~(ones >> n);
  endfunction

  // Width index k: lane width = MAX_WIDTH >> k; any illegal code falls back to k = 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    k_dec = '0;
    for (int n = 1; n <= NW; n++) begin
      if (sew == therm(n)) k_dec = KW'(n - 1);
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_width
    localparam int LW  = MAX_WIDTH >> k;
    localparam int SPL = LW / MIN_WIDTH;
    for (genvar j = 0; j < (1 << k); j++) begin : g_lane
      logic [LW:0]   shifted;
      logic [LW+1:0] diff;
      assign shifted = {rem_q[j*LW +: LW], dvd_q[j*LW+LW-1]};
      assign diff    = {1'b0, shifted} - {2'b00, dsr_q[j*LW +: LW]};
      // diff[LW+1] is the lane borrow; the carry chain never leaves the lane.
      assign rem_nxt[k][j*LW +: LW]    = diff[LW+1] ? shifted[LW-1:0] : diff[LW-1:0];
      assign dvd_nxt[k][j*LW +: LW]    = {dvd_q[j*LW +: LW-1], ~diff[LW+1]};
      assign dbz_lane[k][j*SPL +: SPL] = {SPL{~|dsr_q[j*LW +: LW]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          dvd_q <= dividend;
          dsr_q <= divisor;
          rem_q <= '0;
          k_q   <= k_dec;
          cnt_q <= CW'(MAX_WIDTH >> k_dec);
        end
        BUSY: begin
          dvd_q <= dvd_nxt[k_q];
          rem_q <= rem_nxt[k_q];
          cnt_q <= cnt_q - CW'(1);
          // Dividend register has become the quotient after the last shift.
          if (cnt_q == CW'(1)) begin
            quotient  <= dvd_nxt[k_q];
            remainder <= rem_nxt[k_q];
            dbz       <= dbz_lane[k_q];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_divider.sv
// Directed self-checking bench for simd_divider: lane widths, divide-by-zero,
// illegal sew, backpressure, asynchronous reset mid-operation, and a short random sweep.
module tb_simd_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  sew;
  logic [63:0] dividend, divisor, quotient, remainder;
  logic [7:0]  dbz;

  int nvec = 0;
  int nerr = 0;

  simd_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sew       (sew),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands from #1 after an edge and hold them until the accepting edge.
  task automatic start(input string tag, input logic [3:0] s, input logic [63:0] a, input logic [63:0] b);
    int n;
    sew = s; dividend = a; divisor = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (n >= 300) check({tag, "_accept_timeout"}, 64'(n), 64'd0);
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [3:0] s, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                              input logic [7:0] ez, input int elat);
    int lat;
    start(tag, s, a, b);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, 64'(dbz), 64'(ez));
    consume();
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  // Reference: plain / and % per lane with the zero-divisor rule.
  function automatic int lane_width(input logic [3:0] s);
    case (s)
      4'b1100: return 32;
      4'b1110: return 16;
      4'b1111: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic void model(input logic [3:0] s, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output logic [7:0] z);
    int lw;
    lw = lane_width(s);
    q = '0; r = '0; z = '0;
    for (int j = 0; j < 64 / lw; j++) begin
      logic [63:0] mask, av, bv, qv, rv;
      mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
      av = (a >> (j * lw)) & mask;
      bv = (b >> (j * lw)) & mask;
      if (bv == 64'd0) begin
        qv = mask; rv = av;
        for (int t = 0; t < lw / 8; t++) z[j * (lw / 8) + t] = 1'b1;
      end else begin
        qv = av / bv; rv = av % bv;
      end
      q |= qv << (j * lw);
      r |= rv << (j * lw);
    end
  endfunction

  initial begin
    logic [3:0]  codes [6];
    logic [3:0]  s;
    logic [63:0] a, b, eq, er;
    logic [7:0]  ez;
    int          lat;

    codes[0] = 4'b1000; codes[1] = 4'b1100; codes[2] = 4'b1110;
    codes[3] = 4'b1111; codes[4] = 4'b0110; codes[5] = 4'b1010;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sew = '0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 64-bit lane.
    run_directed("d64", 4'b1000, 64'd1000, 64'd7, 64'd142, 64'd6, 8'h00, 64);

    // Eight 8-bit lanes: FF/0F, 64/07, 0A/03, 09/03, 08/02, 07/02, 04/01, 03/01.
    run_directed("d8", 4'b1111, 64'hFF64_0A09_0807_0403, 64'h0F07_0303_0202_0101,
                 64'h110E_0303_0403_0403, 64'h0002_0100_0001_0000, 8'h00, 8);

    // 16-bit lanes, lane 0 divides by zero; 1000/10, FFFF/10, 77/7 elsewhere.
    run_directed("dbz16", 4'b1110, {16'd1000, 16'hFFFF, 16'd77, 16'h1234},
                 {16'd10, 16'h0010, 16'd7, 16'h0000},
                 {16'd100, 16'h0FFF, 16'd11, 16'hFFFF}, {16'd0, 16'h000F, 16'd0, 16'h1234},
                 8'b0000_0011, 16);

    // Illegal sew codes fall back to one 64-bit lane: 2^32 / 2^16 = 2^16.
    run_directed("ill0110", 4'b0110, 64'h0000_0001_0000_0000, 64'h0000_0000_0001_0000,
                 64'h0000_0000_0001_0000, 64'd0, 8'h00, 64);
    run_directed("ill1010", 4'b1010, 64'd77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd77, 8'hFF, 64);

    // Backpressure: result held for 5 cycles while a new request waits.
    start("bp_a", 4'b1100, {32'd100000, 32'd12345}, {32'd3, 32'd100});
    wait_done(lat);
    check("bp_a_latency", 64'(lat), 64'd32);
    sew = 4'b1000; dividend = 64'hFFFF_FFFF_FFFF_FFFF; divisor = 64'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_quotient", quotient, {32'd33333, 32'd123});
      check("bp_hold_remainder", remainder, {32'd1, 32'd45});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_after_hs_valid", 64'(out_valid), 64'd0);
    check("bp_after_hs_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b_accepted", 64'(in_ready), 64'd0);
    wait_done(lat);
    check("bp_b_latency", 64'(lat), 64'd64);
    check("bp_b_quotient", quotient, 64'h5555_5555_5555_5555);
    check("bp_b_remainder", remainder, 64'd0);
    consume();

    // Asynchronous reset at iteration 10 of a 32-bit divide.
    start("rst_mid", 4'b1100, {32'd5000, 32'd4000}, {32'd7, 32'd9});
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_quotient", quotient, 64'd0);
    check("rst_mid_remainder", remainder, 64'd0);
    check("rst_mid_dbz", 64'(dbz), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_no_result", 64'(out_valid), 64'd0);
    run_directed("post_rst", 4'b1100, {32'd1000, 32'd999}, {32'd10, 32'd9},
                 {32'd100, 32'd111}, 64'd0, 8'h00, 32);

    // Random sweep against the reference model.
    for (int i = 0; i < 16; i++) begin
      s = codes[$urandom_range(0, 5)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) b[15:0] = 16'h0000;
      model(s, a, b, eq, er, ez);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      start("rnd", s, a, b);
      wait_done(lat);
      check("rnd_latency", 64'(lat), 64'(lane_width(s)));
      check("rnd_quotient", quotient, eq);
      check("rnd_remainder", remainder, er);
      check("rnd_dbz", 64'(dbz), 64'(ez));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      consume();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
